// File: rtl/test1_seq.sv
// test1_seq: stimulus sequencer and checker for the test1 datapath.
// Each run drives NUM_VEC LFSR vectors on a_out and compares b_in
// against a model of the datapath's two flop stages. It reports a
// saturating mismatch count, the index of the first failure and a pass flag.
module test1_seq #(
    parameter int         NUM_VEC = 16,
    parameter logic [6:0] SEED    = 7'h01,
    parameter int         IDX_W   = 8,
    parameter int         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [6:0]       a_out,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mism_cnt,
    output logic [IDX_W-1:0] fail_idx,
    output logic             fail_seen
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LAST_K  = IDX_W'(NUM_VEC - 1);
    localparam logic [IDX_W-1:0] FIRST_K = IDX_W'(2);

    state_t           state;
    logic [6:0]       lfsr;     // vector v(k) currently on a_out during RUN
    logic [IDX_W-1:0] k;
    logic             e4_h1;    // e4(v(k-1))
    logic             e4_h2;    // e4(v(k-2))
    logic             e5_h1;    // e5(v(k-1))

    logic expected_b;
    logic cmp_en;
    logic mismatch;
    logic fail_seen_nxt;

    function automatic logic [6:0] lfsr_step(input logic [6:0] v);
        return {v[5:0], v[6] ^ v[5]};
    endfunction

    function automatic logic e4_of(input logic [6:0] v);
        return ~(v[0] & v[1]) & ~v[2];
    endfunction

    function automatic logic e5_of(input logic [6:0] v);
        return v[3] | v[4] | (v[5] & v[6]);
    endfunction

    // Compare qualification: k = 2..NUM_VEC, dropped when abort wins the cycle.
    always_comb begin
        expected_b    = e4_h2 & e5_h1;
        cmp_en        = !abort &&
                        (((state == S_RUN) && (k >= FIRST_K)) || (state == S_DRAIN));
        mismatch      = cmp_en && (b_in != expected_b);
        fail_seen_nxt = fail_seen | mismatch;
    end

    // Sequencer FSM with registered outputs, history pipeline and result tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            lfsr      <= SEED;
            k         <= '0;
            e4_h1     <= 1'b0;
            e4_h2     <= 1'b0;
            e5_h1     <= 1'b0;
            a_out     <= 7'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            mism_cnt  <= '0;
            fail_idx  <= '1;
            fail_seen <= 1'b0;
        end else begin
            done <= 1'b0;

            if (mismatch) begin
                if (mism_cnt != '1) begin
                    mism_cnt <= mism_cnt + CNT_W'(1);
                end
                if (!fail_seen) begin
                    fail_idx  <= k;
                    fail_seen <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        lfsr      <= SEED;
                        a_out     <= SEED;
                        k         <= '0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        mism_cnt  <= '0;
                        fail_idx  <= '1;
                        fail_seen <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        a_out <= 7'h00;
                    end else begin
                        e4_h1 <= e4_of(lfsr);
                        e4_h2 <= e4_h1;
                        e5_h1 <= e5_of(lfsr);
                        k     <= k + IDX_W'(1);
                        if (k == LAST_K) begin
                            state <= S_DRAIN;
                            a_out <= 7'h00;
                        end else begin
                            lfsr  <= lfsr_step(lfsr);
                            a_out <= lfsr_step(lfsr);
                        end
                    end
                end
                S_DRAIN: begin
                    busy <= 1'b0;
                    if (abort) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        pass  <= !fail_seen_nxt;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_test1_seq.sv
// Bench for test1_seq: three instances (NUM_VEC 6, 8 and 10 with a 2-bit
// counter) share a clock. A behavioural test1 datapath feeds b_in, which a
// mode switch can replace by constant 0, constant 1 or the inverted datapath.
module tb_test1_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [2:0]      start;
    logic [2:0]      abort;
    logic [2:0][6:0] a_o;
    logic [2:0]      b_i;
    logic [2:0]      busy;
    logic [2:0]      done;
    logic [2:0]      pass;
    logic [2:0]      fseen;
    logic [7:0]      cnt0;
    logic [7:0]      cnt1;
    logic [1:0]      cnt2;
    logic [2:0][7:0] fidx;
    logic [1:0]      mode;   // 0 datapath, 1 tied 0, 2 tied 1, 3 inverted datapath
    int              sel;

    int n_chk  = 0;
    int n_fail = 0;

    test1_seq #(.NUM_VEC(6), .SEED(7'h01), .IDX_W(8), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
        .a_out(a_o[0]), .b_in(b_i[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .mism_cnt(cnt0), .fail_idx(fidx[0]), .fail_seen(fseen[0])
    );

    test1_seq #(.NUM_VEC(8), .SEED(7'h01), .IDX_W(8), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
        .a_out(a_o[1]), .b_in(b_i[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .mism_cnt(cnt1), .fail_idx(fidx[1]), .fail_seen(fseen[1])
    );

    test1_seq #(.NUM_VEC(10), .SEED(7'h01), .IDX_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .abort(abort[2]),
        .a_out(a_o[2]), .b_in(b_i[2]), .busy(busy[2]), .done(done[2]),
        .pass(pass[2]), .mism_cnt(cnt2), .fail_idx(fidx[2]), .fail_seen(fseen[2])
    );

    function automatic logic e4f(input logic [6:0] v);
        return ~(v[0] & v[1]) & ~v[2];
    endfunction

    function automatic logic e5f(input logic [6:0] v);
        return v[3] | v[4] | (v[5] & v[6]);
    endfunction

    // Behavioural test1: c4 path through two unreset flops, c5 through one.
    logic [2:0] s41, s42, s5, dp_b;
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            s41[i] <= e4f(a_o[i]);
            s42[i] <= s41[i];
            s5[i]  <= e5f(a_o[i]);
        end
    end
    assign dp_b = s42 & s5;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            case (mode)
                2'd0:    b_i[i] = dp_b[i];
                2'd1:    b_i[i] = 1'b0;
                2'd2:    b_i[i] = 1'b1;
                default: b_i[i] = ~dp_b[i];
            endcase
        end
    end

    // Observe whichever instance is under test.
    logic [6:0] cur_a;
    logic       cur_busy, cur_done, cur_pass, cur_fseen;
    logic [7:0] cur_cnt, cur_fidx;
    always_comb begin
        cur_a     = a_o[sel];
        cur_busy  = busy[sel];
        cur_done  = done[sel];
        cur_pass  = pass[sel];
        cur_fseen = fseen[sel];
        cur_fidx  = fidx[sel];
        case (sel)
            0:       cur_cnt = cnt0;
            1:       cur_cnt = cnt1;
            default: cur_cnt = {6'b0, cnt2};
        endcase
    end

    logic [6:0] lit8 [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " a_out"},    32'(cur_a),     32'h0);
        chk({tag, " busy"},     32'(cur_busy),  32'h0);
        chk({tag, " done"},     32'(cur_done),  32'h0);
        chk({tag, " pass"},     32'(cur_pass),  32'h0);
        chk({tag, " mism_cnt"}, 32'(cur_cnt),   32'h0);
        chk({tag, " fail_idx"}, 32'(cur_fidx),  32'hFF);
        chk({tag, " fail_seen"},32'(cur_fseen), 32'h0);
    endtask

    // One full run on instance s with n vectors: the model derives the
    // vector list, the expected datapath output and the result counters,
    // then every cycle from start to one past DONE is compared.
    task automatic run(input int s, input int n, input int cmax, input int glitch_k);
        logic [6:0] v [0:31];
        logic       eb, bb;
        int         cnt_at [0:31];
        int         cnt, fi;
        bit         fs;
        v[0] = 7'h01;
        for (int j = 1; j < n; j++) v[j] = {v[j-1][5:0], v[j-1][6] ^ v[j-1][5]};
        cnt = 0; fi = 255; fs = 0;
        cnt_at[0] = 0; cnt_at[1] = 0; cnt_at[2] = 0;
        for (int j = 2; j <= n; j++) begin
            eb = e4f(v[j-2]) & e5f(v[j-1]);
            case (mode)
                2'd0:    bb = eb;
                2'd1:    bb = 1'b0;
                2'd2:    bb = 1'b1;
                default: bb = ~eb;
            endcase
            if (bb != eb) begin
                if (cnt < cmax) cnt++;
                if (!fs) begin fi = j; fs = 1; end
            end
            cnt_at[j+1] = cnt;
        end

        sel = s;
        @(posedge clk); #1;
        start[s] = 1'b1;
        @(posedge clk); #1;
        start[s] = 1'b0;
        for (int c = 0; c <= n + 2; c++) begin
            if (c < n) begin
                chk("a_out run", 32'(cur_a), 32'(v[c]));
                if (s == 1) chk("a_out literal", 32'(cur_a), 32'(lit8[c]));
                chk("busy run", 32'(cur_busy), 32'h1);
                chk("done run", 32'(cur_done), 32'h0);
            end else if (c == n) begin
                chk("a_out drain", 32'(cur_a), 32'h0);
                chk("busy drain", 32'(cur_busy), 32'h1);
                chk("done drain", 32'(cur_done), 32'h0);
            end else if (c == n + 1) begin
                chk("busy done", 32'(cur_busy), 32'h0);
                chk("done pulse", 32'(cur_done), 32'h1);
                chk("pass", 32'(cur_pass), 32'(cnt == 0));
                chk("fail_idx", 32'(cur_fidx), 32'(fi));
                chk("fail_seen", 32'(cur_fseen), 32'(fs));
            end else begin
                chk("done after", 32'(cur_done), 32'h0);
                chk("busy after", 32'(cur_busy), 32'h0);
            end
            if (c <= n + 1) chk("mism_cnt", 32'(cur_cnt), 32'(cnt_at[c]));
            start[s] = (c == glitch_k) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
        end
        start[s] = 1'b0;
    endtask

    initial begin
        lit8[0] = 7'h01; lit8[1] = 7'h02; lit8[2] = 7'h04; lit8[3] = 7'h08;
        lit8[4] = 7'h10; lit8[5] = 7'h20; lit8[6] = 7'h41; lit8[7] = 7'h03;
        rst = 1'b1; start = '0; abort = '0; mode = 2'd0; sel = 0;

        // Reset state of every instance.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1 chk_reset_vals("reset");
        end
        rst = 1'b0;

        // NUM_VEC=6 against the datapath, then with b tied low and high.
        mode = 2'd0; run(0, 6, 255, -1);
        chk("dp pass lit", 32'(cur_pass), 32'h1);
        chk("dp cnt lit",  32'(cur_cnt),  32'h0);
        chk("dp fidx lit", 32'(cur_fidx), 32'hFF);
        mode = 2'd1; run(0, 6, 255, -1);
        chk("b0 cnt lit",  32'(cur_cnt),  32'h1);
        chk("b0 fidx lit", 32'(cur_fidx), 32'h5);
        chk("b0 pass lit", 32'(cur_pass), 32'h0);
        mode = 2'd2; run(0, 6, 255, -1);
        chk("b1 cnt lit",  32'(cur_cnt),  32'h4);
        chk("b1 fidx lit", 32'(cur_fidx), 32'h2);
        chk("b1 pass lit", 32'(cur_pass), 32'h0);

        // NUM_VEC=8 vector sequence, with a stray start pulse during RUN.
        mode = 2'd0; run(1, 8, 255, 3);

        // Reset in cycle k=3 of a failing run, then a clean run.
        sel = 0; mode = 2'd2;
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre-rst fail_seen", 32'(cur_fseen), 32'h1);
        rst = 1'b1;
        #1 chk_reset_vals("mid-run rst");
        @(posedge clk); #1 rst = 1'b0;
        mode = 2'd0; run(0, 6, 255, -1);

        // Abort in cycle k=4: IDLE next cycle, no done, pass held at 0.
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 abort[0] = 1'b1;
        @(posedge clk); #1 abort[0] = 1'b0;
        chk("abort busy", 32'(cur_busy), 32'h0);
        chk("abort pass", 32'(cur_pass), 32'h0);
        for (int c = 0; c < 4; c++) begin
            chk("abort no done", 32'(cur_done), 32'h0);
            chk("abort idle", 32'(cur_busy), 32'h0);
            @(posedge clk); #1;
        end

        // CNT_W=2 saturation with b inverted on every cycle.
        mode = 2'd3; run(2, 10, 3, -1);
        chk("sat cnt lit",  32'(cur_cnt),  32'h3);
        chk("sat fidx lit", 32'(cur_fidx), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/test1_seq.md
# test1_seq

Self-checking stimulus sequencer for the `test1` gate-level datapath. It drives the 7-bit input `a` with one LFSR vector per clock and samples output `b`. It checks `b` against an internal cycle-accurate model of the datapath's two flop stages and reports a mismatch count, the first failing index and a pass flag. It sits beside the `test1` instance and shares its `clk`; `test1` itself has no reset.

## Interface
Parameters:
- `NUM_VEC`, 16: vectors applied per run. Legal range is 3 to 2^IDX_W − 1.
- `SEED`, 7'h01: LFSR load value on start. Must be nonzero.
- `IDX_W`, 8: width of index outputs.
- `CNT_W`, 8: width of the mismatch counter.

Ports:
- `clk`, in, 1: rising-edge clock, shared with `test1`.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: begin a run. Sampled only in IDLE.
- `abort`, in, 1: stop the run and return to IDLE. Results are left as they are.
- `a_out`, out, 7: vector driven to `test1.a`.
- `b_in`, in, 1: `test1.b`.
- `busy`, out, 1: high in RUN and DRAIN.
- `done`, out, 1: one-cycle pulse when a run completes.
- `pass`, out, 1: high when the last completed run had zero mismatches.
- `mism_cnt`, out, CNT_W: number of mismatches; saturates at all-ones.
- `fail_idx`, out, IDX_W: compare index of the first mismatch. All-ones if there was none.
- `fail_seen`, out, 1: at least one mismatch in the current or last run.

## Operation
- **States:** IDLE → RUN → DRAIN → DONE → IDLE.
  - IDLE + `start` → RUN. The LFSR loads `SEED`, the index k clears to 0, and `mism_cnt`, `fail_seen` and `pass` clear. `fail_idx` is set to all-ones.
  - RUN lasts `NUM_VEC` cycles, k = 0..NUM_VEC−1. In cycle k, `a_out` = v(k).
  - DRAIN lasts 1 cycle, with k = NUM_VEC and `a_out` = 0.
  - DONE lasts 1 cycle. `done`=1 and `pass` = !`fail_seen` is registered.
- **LFSR:** v(0) = SEED; v(k+1) = {v(k)[5:0], v(k)[6]^v(k)[5]}. With SEED = 01 the sequence is 01, 02, 04, 08, 10, 20, 41, 03, …
- **Model terms, per vector:**
  - e4(v) = ~(v[0]&v[1]) & ~v[2]
  - e5(v) = v[3] | v[4] | (v[5]&v[6])
- **Expected output:** the datapath's `b` in cycle k equals e4(v(k−2)) & e5(v(k−1)). This comes from two flop stages on the c4 path and one on the c5 path. The block keeps 2-deep e4 and 1-deep e5 history registers.
- **Compare:** at the end of cycles k = 2..NUM_VEC, `b_in` is compared with the expected value. That gives NUM_VEC−1 compares per run.
  - Cycles 0 and 1 are not compared, because the datapath flops are unreset and may hold stale data.
- **On mismatch:** `mism_cnt` increments, saturating. If `fail_seen` was 0, `fail_idx` takes k and `fail_seen` is set.
- **`start` outside IDLE:** ignored.
- **`abort`:** `abort` in RUN or DRAIN → IDLE next cycle. `done` is not pulsed and `pass` keeps its value from the start of this run, which is 0. `abort` takes priority over a compare in the same cycle, so the compare is discarded.
- **Reset:**
  - `rst` asserted at any time, including mid-run, forces IDLE immediately.
  - Reset values: `a_out`=0, `busy`=0, `done`=0, `pass`=0, `mism_cnt`=0, `fail_idx`=all-ones, `fail_seen`=0, LFSR=SEED.

## Timing
- All outputs are registered and change only on rising `clk` edges, except for the asynchronous clear on reset.
- `start` sampled at edge E0:
  - `busy` and `a_out`=v(0) are valid from E0 to E1.
  - v(k) is driven between edges Ek and Ek+1.
  - `done` is high between edges E(N+1) and E(N+2), where N = NUM_VEC.
  - Latency from `start` to `done` is NUM_VEC+1 cycles.
- `b_in` is sampled at the edge ending cycle k, so the `test1` combinational path must settle within one cycle.
- `pass`, `mism_cnt`, `fail_idx` and `fail_seen` are final from the DONE cycle and are held until the next accepted `start`.
- Back-to-back runs: `start` is accepted in the first IDLE cycle after DONE.

## Test plan
- NUM_VEC=6, SEED=01, `b_in` fed from a real `test1` instance. Expected `b` for k=2..6 is 0, 0, 0, 1, 0. Required result: `done` on cycle 7, `pass`=1, `mism_cnt`=0, `fail_idx`=FF.
- Same run with `b_in` tied to 0 → `mism_cnt`=1, `fail_idx`=5, `pass`=0.
- Same run with `b_in` tied to 1 → `mism_cnt`=4, `fail_idx`=2, `pass`=0.
- Check `a_out` during RUN with SEED=01 and NUM_VEC=8. Required sequence: 01, 02, 04, 08, 10, 20, 41, 03, then 00 in DRAIN. `start` pulses during RUN are ignored.
- Assert `rst` at k=3 of a run → all outputs at reset values immediately, and a new `start` runs cleanly. Assert `abort` at k=4 → IDLE next cycle, no `done`, `pass`=0.
- CNT_W=2, NUM_VEC=10, `b_in` = ~expected on every cycle → `mism_cnt` saturates at 3 and `fail_idx`=2.
